// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_pkg
//  Description : Shared constants, types and helpers for the systolic MAC
//                array datapath (array geometry and operand/result widths).
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package systolic_pkg;

    localparam int MAC_ROW         = 16;
    localparam int MAC_COL         = 16;
    localparam int W_BITWIDTH      = 8;
    localparam int INPUT_BITWIDTH  = 8;
    localparam int OUTPUT_BITWIDTH = 32;

    // One aligned row of column results, lane j in bits [j*OB +: OB].
    typedef logic [MAC_COL*OUTPUT_BITWIDTH-1:0] psum_word_t;

    // Number of MAC_COL-wide words that make up one row x col output matrix.
    function automatic int total_words(input int row, input int col);
        return (row * col) / MAC_COL;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_sa.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_sa
//  Description : Single-clock show-ahead FIFO. The head entry is visible on
//                data_out whenever the FIFO is not empty; when empty, the
//                last shown value is held. Sticky overflow/underflow flags.
//  Ports       : clk, rst (async, active-high), clear_in (sync flush)
//                push_in/push_data_in   - write side
//                pop_in                 - read side, consumes head entry
//                data_out               - head entry (show-ahead)
//                count_out              - entries held, 0..DEPTH
//                full_out, empty_out    - occupancy status
//                overflow_out           - sticky: push while full, no pop
//                underflow_out          - sticky: pop while empty
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_sa #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear_in,
    input  logic                   push_in,
    input  logic [WIDTH-1:0]       push_data_in,
    input  logic                   pop_in,
    output logic [WIDTH-1:0]       data_out,
    output logic [$clog2(DEPTH):0] count_out,
    output logic                   full_out,
    output logic                   empty_out,
    output logic                   overflow_out,
    output logic                   underflow_out
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0]   hold_q, hold_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;

    logic               w_empty;
    logic               w_full;
    logic               w_do_pop;
    logic               w_do_write;

    assign w_empty = (count_q == '0);
    assign w_full  = (count_q == c_CNT_W'(DEPTH));

    always_comb begin
        // A pop is only honoured when there is something to read. A push into
        // a full FIFO still succeeds if a pop frees a slot in the same cycle.
        w_do_pop   = pop_in & ~w_empty;
        w_do_write = push_in & (~w_full | w_do_pop) & ~clear_in;

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q | (push_in & w_full & ~pop_in);
        underflow_d = underflow_q | (pop_in & w_empty);

        if (w_do_write) begin
            wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
        end
        if (w_do_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
        end

        case ({w_do_write, w_do_pop})
            2'b10:   count_d = count_q + c_CNT_W'(1);
            2'b01:   count_d = count_q - c_CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Remember whatever is on the output so it can be held once empty.
        hold_d = data_out;

        if (clear_in) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            hold_d      = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            hold_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            hold_q      <= hold_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is never read before it is written, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            mem_q[wr_ptr_q] <= push_data_in;
        end
    end

    assign data_out      = w_empty ? hold_q : mem_q[rd_ptr_q];
    assign count_out     = count_q;
    assign full_out      = w_full;
    assign empty_out     = w_empty;
    assign overflow_out  = overflow_q;
    assign underflow_out = underflow_q;

endmodule
`default_nettype wire

// File: rtl/output_deskew_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : output_deskew_buffer
//  Description : Re-aligns the diagonally skewed column results leaving the
//                bottom of the systolic MAC array into one MAC_COL-wide word,
//                buffers the words in a show-ahead FIFO for the output RAM,
//                flags protocol faults and pulses drain_done_out once a full
//                output matrix has been drained.
//  Ports       : clk, rst (async, active-high), clear_in (sync flush)
//                psum_valid_in/psum_in - per-column valid/data, skewed
//                pop_in                - output_write_en from MemoryController
//                wdata_out             - FIFO head word
//                empty_out/full_out/count_out - FIFO status
//                skew_err_out/overflow_out/underflow_out - sticky faults
//                drain_done_out        - pulse after last word of a matrix
//  Revision    : 1.0 - initial release
// ============================================================================
module output_deskew_buffer
    import systolic_pkg::*;
#(
    parameter int MAC_COL         = systolic_pkg::MAC_COL,
    parameter int OUTPUT_BITWIDTH = systolic_pkg::OUTPUT_BITWIDTH,
    parameter int FIFO_DEPTH      = 32,
    parameter int OUTPUT_ROW      = 64,
    parameter int OUTPUT_COL      = 196
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clear_in,
    input  logic [MAC_COL-1:0]                 psum_valid_in,
    input  logic [MAC_COL*OUTPUT_BITWIDTH-1:0] psum_in,
    input  logic                               pop_in,
    output logic [MAC_COL*OUTPUT_BITWIDTH-1:0] wdata_out,
    output logic                               empty_out,
    output logic                               full_out,
    output logic [$clog2(FIFO_DEPTH):0]        count_out,
    output logic                               skew_err_out,
    output logic                               overflow_out,
    output logic                               underflow_out,
    output logic                               drain_done_out
);

    localparam int c_WORD_W      = MAC_COL * OUTPUT_BITWIDTH;
    localparam int c_TOTAL_WORDS = total_words(OUTPUT_ROW, OUTPUT_COL);
    localparam int c_DRAIN_W     = (c_TOTAL_WORDS > 1) ? $clog2(c_TOTAL_WORDS) : 1;

    // ------------------------------------------------------------------
    // Deskew triangle: lane j is delayed MAC_COL-1-j cycles so that all
    // lanes of one array row arrive at the align register together.
    // ------------------------------------------------------------------
    logic [OUTPUT_BITWIDTH-1:0] w_lane_data [MAC_COL];
    logic [MAC_COL-1:0]         w_lane_valid;

    for (genvar j = 0; j < MAC_COL; j++) begin : g_lane
        localparam int c_DEPTH = MAC_COL - 1 - j;

        if (c_DEPTH == 0) begin : g_direct
            assign w_lane_data[j]  = psum_in[j*OUTPUT_BITWIDTH +: OUTPUT_BITWIDTH];
            assign w_lane_valid[j] = psum_valid_in[j];
        end else begin : g_delay
            logic [OUTPUT_BITWIDTH-1:0] data_q [c_DEPTH];
            logic [OUTPUT_BITWIDTH-1:0] data_d [c_DEPTH];
            logic [c_DEPTH-1:0]         valid_q;
            logic [c_DEPTH-1:0]         valid_d;

            always_comb begin
                data_d[0]  = psum_in[j*OUTPUT_BITWIDTH +: OUTPUT_BITWIDTH];
                valid_d[0] = psum_valid_in[j];
                for (int s = 1; s < c_DEPTH; s++) begin
                    data_d[s]  = data_q[s-1];
                    valid_d[s] = valid_q[s-1];
                end
                if (clear_in) begin
                    for (int s = 0; s < c_DEPTH; s++) begin
                        data_d[s] = '0;
                    end
                    valid_d = '0;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int s = 0; s < c_DEPTH; s++) begin
                        data_q[s] <= '0;
                    end
                    valid_q <= '0;
                end else begin
                    for (int s = 0; s < c_DEPTH; s++) begin
                        data_q[s] <= data_d[s];
                    end
                    valid_q <= valid_d;
                end
            end

            assign w_lane_data[j]  = data_q[c_DEPTH-1];
            assign w_lane_valid[j] = valid_q[c_DEPTH-1];
        end
    end

    // ------------------------------------------------------------------
    // Common align register and push / skew-fault decision.
    // ------------------------------------------------------------------
    logic [c_WORD_W-1:0]  align_data_q, align_data_d;
    logic [MAC_COL-1:0]   align_valid_q, align_valid_d;
    logic                 skew_err_q, skew_err_d;
    logic [c_DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic                 drain_done_q, drain_done_d;

    logic                 w_push;
    logic                 w_partial;
    logic                 w_pop_ok;

    // A word is complete only when every lane is valid; any other non-zero
    // pattern means the array delivered misaligned columns and the word is
    // discarded rather than written partially.
    assign w_push    = &align_valid_q;
    assign w_partial = (|align_valid_q) & ~w_push;
    assign w_pop_ok  = pop_in & ~empty_out;

    always_comb begin
        for (int j = 0; j < MAC_COL; j++) begin
            align_data_d[j*OUTPUT_BITWIDTH +: OUTPUT_BITWIDTH] = w_lane_data[j];
        end
        align_valid_d = w_lane_valid;
        skew_err_d    = skew_err_q | w_partial;
        drain_cnt_d   = drain_cnt_q;
        drain_done_d  = 1'b0;

        if (w_pop_ok) begin
            if (drain_cnt_q == c_DRAIN_W'(c_TOTAL_WORDS - 1)) begin
                drain_cnt_d  = '0;
                drain_done_d = 1'b1;
            end else begin
                drain_cnt_d = drain_cnt_q + c_DRAIN_W'(1);
            end
        end

        if (clear_in) begin
            align_data_d  = '0;
            align_valid_d = '0;
            skew_err_d    = 1'b0;
            drain_cnt_d   = '0;
            drain_done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            align_data_q  <= '0;
            align_valid_q <= '0;
            skew_err_q    <= 1'b0;
            drain_cnt_q   <= '0;
            drain_done_q  <= 1'b0;
        end else begin
            align_data_q  <= align_data_d;
            align_valid_q <= align_valid_d;
            skew_err_q    <= skew_err_d;
            drain_cnt_q   <= drain_cnt_d;
            drain_done_q  <= drain_done_d;
        end
    end

    // ------------------------------------------------------------------
    // Output buffer
    // ------------------------------------------------------------------
    sync_fifo_sa #(
        .WIDTH (c_WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst           (rst),
        .clear_in      (clear_in),
        .push_in       (w_push),
        .push_data_in  (align_data_q),
        .pop_in        (pop_in),
        .data_out      (wdata_out),
        .count_out     (count_out),
        .full_out      (full_out),
        .empty_out     (empty_out),
        .overflow_out  (overflow_out),
        .underflow_out (underflow_out)
    );

    assign skew_err_out   = skew_err_q;
    assign drain_done_out = drain_done_q;

endmodule
`default_nettype wire

// File: tb/tb_output_deskew_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_output_deskew_buffer
//  Description : Directed self-checking bench for output_deskew_buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_output_deskew_buffer;

    localparam int MC    = 16;
    localparam int OB    = 32;
    localparam int WW    = MC * OB;
    localparam int DEPTH = 32;
    localparam int TOTAL = 784;

    logic            clk = 1'b0;
    logic            rst;
    logic            clear_in;
    logic [MC-1:0]   psum_valid_in;
    logic [WW-1:0]   psum_in;
    logic            pop_in;
    logic [WW-1:0]   wdata_out;
    logic            empty_out;
    logic            full_out;
    logic [5:0]      count_out;
    logic            skew_err_out;
    logic            overflow_out;
    logic            underflow_out;
    logic            drain_done_out;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          s_start, s_n, s_c, s_early;
    bit          s_on;
    logic [31:0] g_base;
    int          exp_rd;
    int          dd_cnt;

    always #5 clk = ~clk;

    output_deskew_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .clear_in       (clear_in),
        .psum_valid_in  (psum_valid_in),
        .psum_in        (psum_in),
        .pop_in         (pop_in),
        .wdata_out      (wdata_out),
        .empty_out      (empty_out),
        .full_out       (full_out),
        .count_out      (count_out),
        .skew_err_out   (skew_err_out),
        .overflow_out   (overflow_out),
        .underflow_out  (underflow_out),
        .drain_done_out (drain_done_out)
    );

    function automatic logic [31:0] lane_val(input logic [31:0] base, input int w, input int j);
        return base + (32'(w) << 8) + 32'(j);
    endfunction

    function automatic logic [WW-1:0] word_val(input logic [31:0] base, input int w);
        logic [WW-1:0] r;
        for (int j = 0; j < MC; j++) r[j*OB +: OB] = lane_val(base, w, j);
        return r;
    endfunction

    task automatic chkw(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Lane j carries word (s_c - j) of the current stream; s_early moves one
    // lane a cycle ahead of its slot.
    task automatic drive_lanes();
        for (int j = 0; j < MC; j++) begin
            int w;
            w = (j == s_early) ? (s_c + 1 - j) : (s_c - j);
            if (s_on && w >= 0 && w < s_n) begin
                psum_valid_in[j]     = 1'b1;
                psum_in[j*OB +: OB]  = lane_val(g_base, s_start + w, j);
            end else begin
                psum_valid_in[j]     = 1'b0;
                psum_in[j*OB +: OB]  = '0;
            end
        end
    endtask

    task automatic tick(input bit pop);
        bit popped;
        popped = 1'b0;
        drive_lanes();
        pop_in = pop;
        if (pop && !empty_out) begin
            chkw($sformatf("pop_word_%0d", exp_rd), wdata_out, word_val(g_base, exp_rd));
            exp_rd++;
            popped = 1'b1;
        end
        @(posedge clk);
        #1;
        s_c++;
        if (drain_done_out) dd_cnt++;
        if (popped || drain_done_out)
            chk1("drain_done", drain_done_out, popped && (exp_rd == TOTAL));
    endtask

    task automatic stream(input int start, input int n, input bit auto_pop, input int abort_at);
        s_start = start;
        s_n     = n;
        s_c     = 0;
        s_on    = 1'b1;
        for (int k = 0; k < n + MC - 1; k++) begin
            if (abort_at >= 0 && exp_rd >= abort_at) break;
            tick(auto_pop && !empty_out);
        end
        s_on = 1'b0;
        drive_lanes();
    endtask

    task automatic do_clear();
        clear_in = 1'b1;
        s_on     = 1'b0;
        tick(1'b0);
        clear_in = 1'b0;
        exp_rd   = 0;
    endtask

    task automatic chk_idle(input string tag);
        chk1({tag, "_empty"}, empty_out, 1'b1);
        chk1({tag, "_full"}, full_out, 1'b0);
        chkn({tag, "_count"}, int'(count_out), 0);
        chkw({tag, "_wdata"}, wdata_out, '0);
        chk1({tag, "_skew"}, skew_err_out, 1'b0);
        chk1({tag, "_ovf"}, overflow_out, 1'b0);
        chk1({tag, "_udf"}, underflow_out, 1'b0);
        chk1({tag, "_done"}, drain_done_out, 1'b0);
    endtask

    initial begin
        rst           = 1'b1;
        clear_in      = 1'b0;
        pop_in        = 1'b0;
        psum_valid_in = '0;
        psum_in       = '0;
        s_on          = 1'b0;
        s_early       = -1;
        s_c           = 0;
        s_n           = 0;
        s_start       = 0;
        exp_rd        = 0;
        dd_cnt        = 0;
        g_base        = 32'h0000_1000;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset");
        rst = 1'b0;

        // Pop in the very first cycle
        tick(1'b1);
        chk1("first_pop_udf", underflow_out, 1'b1);
        chkn("first_pop_count", int'(count_out), 0);
        chk1("first_pop_empty", empty_out, 1'b1);
        do_clear();
        chk1("clear_udf", underflow_out, 1'b0);

        // Single word: 16-cycle latency, pop coinciding with push into empty
        g_base = 32'h0000_1000;
        stream(0, 1, 1'b0, -1);
        chkn("single_early_count", int'(count_out), 0);
        chk1("single_early_empty", empty_out, 1'b1);
        tick(1'b1);
        chkn("single_count", int'(count_out), 1);
        chk1("single_empty", empty_out, 1'b0);
        chk1("single_udf", underflow_out, 1'b1);
        chkw("single_word", wdata_out, word_val(32'h0000_1000, 0));
        chkn("single_lane15", int'(wdata_out[15*OB +: OB]), 32'h0000_100F);
        tick(1'b1);
        chk1("single_pop_empty", empty_out, 1'b1);
        chkn("single_pop_count", int'(count_out), 0);
        do_clear();

        // Back-to-back 40 words, no pops
        g_base = 32'hA500_0000;
        stream(0, 40, 1'b0, -1);
        tick(1'b0);
        chk1("b2b_full", full_out, 1'b1);
        chkn("b2b_count", int'(count_out), DEPTH);
        chk1("b2b_ovf", overflow_out, 1'b1);
        for (int k = 0; k < DEPTH; k++) tick(1'b1);
        chk1("b2b_drained_empty", empty_out, 1'b1);
        chkn("b2b_drained_rd", exp_rd, DEPTH);
        do_clear();

        // Concurrent push and pop while full
        g_base = 32'h5A00_0000;
        stream(0, DEPTH, 1'b0, -1);
        tick(1'b0);
        chkn("conc_pre_count", int'(count_out), DEPTH);
        chk1("conc_pre_full", full_out, 1'b1);
        chk1("conc_pre_ovf", overflow_out, 1'b0);
        stream(DEPTH, 1, 1'b0, -1);
        tick(1'b1);
        chkn("conc_count", int'(count_out), DEPTH);
        chk1("conc_full", full_out, 1'b1);
        chk1("conc_ovf", overflow_out, 1'b0);
        for (int k = 0; k < DEPTH; k++) tick(1'b1);
        chk1("conc_drained_empty", empty_out, 1'b1);
        do_clear();

        // Skew fault: lane 5 one cycle early
        g_base  = 32'h0000_2000;
        s_early = 5;
        stream(0, 1, 1'b0, -1);
        s_early = -1;
        tick(1'b0);
        tick(1'b0);
        chk1("skew_flag", skew_err_out, 1'b1);
        chkn("skew_count", int'(count_out), 0);
        chk1("skew_empty", empty_out, 1'b1);
        do_clear();
        chk1("skew_cleared", skew_err_out, 1'b0);

        // Full frame, aborted by reset at word 300, then rerun
        g_base = 32'hC000_0000;
        stream(0, TOTAL, 1'b1, 300);
        chkn("abort_rd", exp_rd, 300);
        rst = 1'b1;
        #1;
        chkn("async_rst_count", int'(count_out), 0);
        chk1("async_rst_empty", empty_out, 1'b1);
        chkw("async_rst_wdata", wdata_out, '0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        exp_rd = 0;
        chk1("abort_no_done", drain_done_out, 1'b0);
        stream(0, TOTAL, 1'b1, -1);
        for (int k = 0; k < 40 && !empty_out; k++) tick(1'b1);
        tick(1'b0);
        chk1("frame_empty", empty_out, 1'b1);
        chkn("frame_pops", exp_rd, TOTAL);
        chkn("frame_done_pulses", dd_cnt, 1);
        chk1("frame_ovf", overflow_out, 1'b0);
        chk1("frame_udf", underflow_out, 1'b0);
        chk1("frame_skew", skew_err_out, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
